uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Synthesizable UART receiver. Deserializes an asynchronous RXD line into parallel characters on a valid/ready stream.
- Sits directly downstream of the UART serial line driven by the testbench UART model's TXD. Frame format matches that model: start bit, DW data bits LSB first, optional parity, SW stop bits.
- Bit timing comes from a runtime clock divider. Parity and framing errors are reported alongside each character.

Parameters:
- DW, 8: data bits per character, 5..8.
- SW, 1: stop bits checked, >=1.
- PARITY, "NONE": "NONE", "EVEN" or "ODD". EVEN means the parity bit equals ^dat; ODD means it equals ~^dat.
- CW, 16: width of the divider config.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- cfg_div  input  CW  clocks per bit (N), N>=4; latched at start-bit detection
- rxd  input  1  asynchronous serial data, idle high
- dat_vld  output  1  character available
- dat_rdy  input  1  consumer accepts character
- dat  output  DW  received character
- err_par  output  1  parity error for the character in dat (0 when PARITY="NONE")
- err_frm  output  1  one or more stop bits sampled low for the character in dat
- sta_ovr  output  1  one-cycle pulse: completed character dropped
- sta_bsy  output  1  FSM not in IDLE

Behaviour:
- Reset: on rising clk with rst_n=0:
  - both synchronizer flops = 1; FSM = IDLE; counters = 0.
  - dat_vld=0, dat=0, err_par=0, err_frm=0, sta_ovr=0, sta_bsy=0.
  - Reset mid-frame aborts the frame and discards partial data.
- Synchronizer: 2-flop rxd -> rxs, plus a delayed copy rxs_d.
  - Start edge = rxs_d=1 && rxs=0.
  - A line held low (break) cannot retrigger without first returning high.
- Counter: down-counter cnt.
  - On start edge: div_l <= cfg_div; cnt <= floor(cfg_div/2)-1.
  - Sample when cnt==0, then reload cnt <= div_l-1. Every sample therefore lands mid-bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on start edge.
  - START, sample: rxs=1 means false start (glitch) -> IDLE, no output. Otherwise -> DATA, bit index i=0.
  - DATA, sample: shift reg[i] <= rxs; after i==DW-1 go to PARITY if PARITY!="NONE", else STOP.
  - PARITY, sample: perr <= (rxs != expected parity) -> STOP, stop index j=0.
  - STOP, sample: ferr |= (rxs==0); after j==SW-1 -> deliver, then IDLE. No wait for line idle beyond the edge detector.
- Deliver happens on the clock edge of the last stop sample; outputs are visible the following cycle:
  - If dat_vld==0 or dat_rdy==1 that cycle: dat<=reg, err_par<=perr, err_frm<=ferr, dat_vld<=1.
  - Otherwise the new character is dropped, dat/err are unchanged, and sta_ovr=1 for exactly one cycle.
- Stream handshake:
  - Transfer occurs when dat_vld && dat_rdy.
  - After a transfer with no simultaneous deliver, dat_vld<=0.
  - Deliver and transfer in the same cycle: the new character is loaded, dat_vld stays 1, no overrun.
  - dat, err_par and err_frm are stable while dat_vld && !dat_rdy.
- sta_bsy = (state != IDLE).
- cfg_div changes during a frame have no effect until the next start edge.
- Total frame sample time from edge detect to deliver is (1+DW+P+SW-1)*N + floor(N/2) cycles, where P=1 when parity is enabled.

Test Plan:
- DW=8, SW=1, PARITY="EVEN", cfg_div=16, model BAUD matched; send 0x55 then 0xA3 -> dat_vld twice, dat=0x55 then 0xA3, err_par=0, err_frm=0, sta_ovr=0.
- Same setup, drive a frame for 0x0F with the parity bit inverted -> dat=0x0F, err_par=1, err_frm=0. Next correct frame 0x01 -> err_par=0.
- Frame 0x80 with the stop bit forced low, then line held low 40 bit times -> one character, err_frm=1; no further dat_vld until rxd returns high and a new start edge arrives.
- rxd low pulse of 3 clocks with cfg_div=16 -> sta_bsy pulses, no dat_vld, FSM back in IDLE.
- dat_rdy=0; send 0x11, 0x22 back-to-back -> dat=0x11 held, sta_ovr one-cycle pulse at the end of 0x22. Then dat_rdy=1 -> 0x11 accepted, dat_vld=0.
- Assert rst_n=0 for one cycle mid-DATA of 0x5A -> all outputs 0, no delivery; next frame 0x3C received correctly. Also: dat_rdy=1 constantly with back-to-back frames -> no overrun, all characters in order.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized RXD, mid-bit sampling from a runtime divider,
// valid/ready character output with parity/framing flags and an overrun pulse.
module uart_rx #(
  parameter int    DW     = 8,
  parameter int    SW     = 1,
  parameter string PARITY = "NONE",
  parameter int    CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cfg_div,
  input  logic          rxd,
  output logic          dat_vld,
  input  logic          dat_rdy,
  output logic [DW-1:0] dat,
  output logic          err_par,
  output logic          err_frm,
  output logic          sta_ovr,
  output logic          sta_bsy
);

  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam int NMAX    = (DW > SW) ? DW : SW;
  localparam int IW      = $clog2(NMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rxs_q, rxs_d;
  logic          rxs_dly_q, rxs_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          dat_vld_q, dat_vld_d;
  logic          err_par_q, err_par_d;
  logic          err_frm_q, err_frm_d;
  logic          sta_ovr_q, sta_ovr_d;
  logic          sample;
  logic          deliver;

  always_comb begin
    state_d   = state_q;
    sync1_d   = rxd;
    rxs_d     = sync1_q;
    rxs_dly_d = rxs_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    dat_d     = dat_q;
    dat_vld_d = dat_vld_q;
    err_par_d = err_par_q;
    err_frm_d = err_frm_q;
    sta_ovr_d = 1'b0;
    deliver   = 1'b0;
    sample    = (state_q != S_IDLE) && (cnt_q == '0);

    // Reload by a full bit period after each sample so every sample stays mid-bit.
    if (state_q != S_IDLE) begin
      cnt_d = sample ? (div_q - CW'(1)) : (cnt_q - CW'(1));
    end

    case (state_q)
      S_IDLE: begin
        if (rxs_dly_q && !rxs_q) begin
          state_d = S_START;
          div_d   = cfg_div;
          cnt_d   = (cfg_div >> 1) - CW'(1);
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (sample) begin
          state_d = rxs_q ? S_IDLE : S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {rxs_q, shreg_q[DW-1:1]};
          if (idx_q == IW'(DW - 1)) begin
            idx_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_d  = (rxs_q != (PAR_ODD ? ~^shreg_q : ^shreg_q));
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          ferr_d = ferr_q | ~rxs_q;
          if (idx_q == IW'(SW - 1)) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A held character is only replaced when the consumer takes it this same cycle.
    if (deliver) begin
      if (!dat_vld_q || dat_rdy) begin
        dat_d     = shreg_q;
        err_par_d = perr_q;
        err_frm_d = ferr_d;
        dat_vld_d = 1'b1;
      end else begin
        sta_ovr_d = 1'b1;
      end
    end else if (dat_vld_q && dat_rdy) begin
      dat_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      dat_q     <= '0;
      dat_vld_q <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      sta_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rxs_q     <= rxs_d;
      rxs_dly_q <= rxs_dly_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      dat_q     <= dat_d;
      dat_vld_q <= dat_vld_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      sta_ovr_q <= sta_ovr_d;
    end
  end

  assign dat_vld = dat_vld_q;
  assign dat     = dat_q;
  assign err_par = err_par_q;
  assign err_frm = err_frm_q;
  assign sta_ovr = sta_ovr_q;
  assign sta_bsy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (DW=8, SW=1, EVEN parity, 16 clocks per bit):
// stimulus pushes expected characters, a monitor pops them on each stream transfer.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_div = 16'd16;
  logic        rxd = 1'b1;
  logic        dat_rdy = 1'b0;
  logic        dat_vld;
  logic [7:0]  dat;
  logic        err_par;
  logic        err_frm;
  logic        sta_ovr;
  logic        sta_bsy;

  uart_rx #(.DW(8), .SW(1), .PARITY("EVEN"), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .rxd(rxd),
    .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat(dat),
    .err_par(err_par), .err_frm(err_frm), .sta_ovr(sta_ovr), .sta_bsy(sta_bsy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   rx_cnt = 0;
  logic bsy_seen = 1'b0;
  logic prev_hold = 1'b0;
  logic prev_ovr = 1'b0;
  logic [9:0] prev_out = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // One bit period on the line, aligned 1ns after a rising edge.
  task automatic bit_time(input logic v);
    rxd = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pflip, input logic stop_v, input logic push);
    exp_t e;
    e.d = d;
    e.p = pflip;
    e.f = ~stop_v;
    if (push) exp_q.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time((^d) ^ pflip);
    bit_time(stop_v);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_ovr  = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", {dat, err_par, err_frm}, prev_out);
      if (dat_vld && dat_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char got=%02h exp=none", dat);
        end else begin
          mon_e = exp_q.pop_front();
          $display("rx dat=%02h err_par=%0d err_frm=%0d (exp %02h %0d %0d)",
                   dat, err_par, err_frm, mon_e.d, mon_e.p, mon_e.f);
          chk("char", {dat, err_par, err_frm}, mon_e);
          rx_cnt++;
        end
      end
      if (sta_ovr) begin
        ovr_cnt++;
        chk("ovr_width", prev_ovr, 0);
      end
      if (sta_bsy) bsy_seen = 1'b1;
      prev_hold = dat_vld && !dat_rdy;
      prev_out  = {dat, err_par, err_frm};
      prev_ovr  = sta_ovr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int ovr0;
    int rx0;
    logic [7:0] partial;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", dat_vld, 0);
    chk("rst_dat", dat, 0);
    chk("rst_err", {err_par, err_frm}, 0);
    chk("rst_ovr", sta_ovr, 0);
    chk("rst_bsy", sta_bsy, 0);
    rst_n = 1'b1;
    bit_time(1'b1);

    // Basic reception, correct parity.
    dat_rdy = 1'b1;
    send(8'h55, 1'b0, 1'b1, 1'b1);
    send(8'hA3, 1'b0, 1'b1, 1'b1);
    drain();

    // Parity error then a clean frame.
    send(8'h0F, 1'b1, 1'b1, 1'b1);
    send(8'h01, 1'b0, 1'b1, 1'b1);
    drain();

    // Framing error followed by a long break: exactly one character.
    rx0 = rx_cnt;
    send(8'h80, 1'b0, 1'b0, 1'b1);
    repeat (40) bit_time(1'b0);
    chk("break_idle", sta_bsy, 0);
    chk("break_count", rx_cnt - rx0, 1);
    bit_time(1'b1);
    bit_time(1'b1);
    send(8'h01, 1'b0, 1'b1, 1'b1);
    drain();
    chk("after_break_count", rx_cnt - rx0, 2);

    // Short glitch is rejected as a false start.
    rx0 = rx_cnt;
    bsy_seen = 1'b0;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_bsy_seen", bsy_seen, 1);
    chk("glitch_idle", sta_bsy, 0);
    chk("glitch_no_char", rx_cnt - rx0, 0);

    // Overrun: consumer stalled across two frames.
    dat_rdy = 1'b0;
    ovr0 = ovr_cnt;
    send(8'h11, 1'b0, 1'b1, 1'b1);
    send(8'h22, 1'b0, 1'b1, 1'b0);
    bit_time(1'b1);
    chk("ovr_count", ovr_cnt - ovr0, 1);
    chk("ovr_vld_held", dat_vld, 1);
    chk("ovr_dat_held", dat, 8'h11);
    dat_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_vld_clear", dat_vld, 0);
    drain();

    // Reset in the middle of the data bits of 0x5A.
    partial = 8'h5A;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(partial[i]);
    chk("mid_bsy", sta_bsy, 1);
    rxd = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_vld", dat_vld, 0);
    chk("mid_rst_dat", dat, 0);
    chk("mid_rst_err", {err_par, err_frm}, 0);
    chk("mid_rst_bsy", sta_bsy, 0);
    rx0 = rx_cnt;
    repeat (6) bit_time(1'b1);
    chk("mid_rst_no_char", rx_cnt - rx0, 0);
    send(8'h3C, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back frames with a ready consumer.
    ovr0 = ovr_cnt;
    rx0 = rx_cnt;
    send(8'hC3, 1'b0, 1'b1, 1'b1);
    send(8'h7E, 1'b0, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b1, 1'b1);
    send(8'hFF, 1'b0, 1'b1, 1'b1);
    bit_time(1'b1);
    drain();
    chk("b2b_no_ovr", ovr_cnt - ovr0, 0);
    chk("b2b_count", rx_cnt - rx0, 4);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
